// File: rtl/serial_axis_rx_fifo.sv
// serial_axis_rx_fifo: oversampling UART receiver with majority voting, FWFT FIFO and AXI-Stream output; parity checking enabled by SERIAL_AXIS_RX_PARITY_EN
module serial_axis_rx_fifo #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int TERM_EN = 1,
  parameter logic [7:0] TERM_BYTE = 8'hFF
`ifdef SERIAL_AXIS_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic [7:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic frame_err,
  output logic overrun_err,
  output logic parity_err
);
  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DCW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int LW = FAW + 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
`ifdef SERIAL_AXIS_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic [DCW-1:0] div_cnt;
  logic os_tick;
  logic [1:0] sync;
  logic rx;
  logic [AW-1:0] arm_cnt;
  logic armed;
  logic [2:0] state;
  logic [PW-1:0] phase;
  logic s_a, s_b;
  logic vote_tick, vote;
  logic [BW-1:0] bit_idx;
  logic stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic stop_done, push, pop, full, wr_en;
  logic [7:0] char;
  logic [8:0] mem [FIFO_DEPTH];
  logic [8:0] head;
  logic [LW-1:0] wr_ptr, rd_ptr;
`ifdef SERIAL_AXIS_RX_PARITY_EN
  logic par_bad;
`endif

  assign os_tick = div_cnt == DCW'(DIV - 1);
  assign rx = sync[1];
  assign vote_tick = os_tick && phase == PW'(OVERSAMPLE / 2 + 1);
  assign vote = (s_a & s_b) | (s_a & rx) | (s_b & rx);
  assign stop_done = state == STOP && vote_tick && vote && stop_idx == 1'(STOP_BITS - 1);
  assign frame_err = state == STOP && vote_tick && !vote;
`ifdef SERIAL_AXIS_RX_PARITY_EN
  assign push = stop_done && !par_bad;
  assign parity_err = stop_done && par_bad;
`else
  assign push = stop_done;
  assign parity_err = 1'b0;
`endif
  assign char = 8'(shreg);
  assign fifo_level = wr_ptr - rd_ptr;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign m_axis_tvalid = fifo_level != '0;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign wr_en = push && (!full || pop);
  assign overrun_err = push && full && !pop;
  assign head = mem[rd_ptr[FAW-1:0]];
  assign m_axis_tdata = m_axis_tvalid ? head[7:0] : '0;
  assign m_axis_tlast = m_axis_tvalid && head[8];

  // Free-running oversample tick divider
  always_ff @(posedge clk)
    div_cnt <= rst || os_tick ? '0 : div_cnt + 1'b1;

  // Two-flop synchroniser, idle high
  always_ff @(posedge clk)
    sync <= rst ? 2'b11 : {sync[0], uart_rx};

  // Arm only after the line has idled high for a full bit so a reset mid-character yields nothing
  always_ff @(posedge clk)
    if (rst) begin
      arm_cnt <= '0;
      armed <= 1'b0;
    end else if (!rx) arm_cnt <= '0;
    else if (os_tick && !armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      armed <= arm_cnt == AW'(OVERSAMPLE - 1);
    end

  // Receive FSM: bit phase keeps running across states so each vote lands mid-bit
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      s_a <= 1'b1;
      s_b <= 1'b1;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      shreg <= '0;
`ifdef SERIAL_AXIS_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      if (os_tick) begin
        phase <= phase == PW'(OVERSAMPLE - 1) ? '0 : phase + 1'b1;
        if (phase == PW'(OVERSAMPLE / 2 - 1)) s_a <= rx;
        if (phase == PW'(OVERSAMPLE / 2)) s_b <= rx;
      end
      case (state)
        IDLE: if (armed && !rx) begin
          state <= START;
          phase <= '0;
        end
        START: if (vote_tick) begin
          state <= vote ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (vote_tick) begin
          shreg <= {vote, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          stop_idx <= 1'b0;
          if (bit_idx == BW'(DATA_BITS - 1)) state <= AFTER_DATA;
        end
`ifdef SERIAL_AXIS_RX_PARITY_EN
        PARITY: if (vote_tick) begin
          par_bad <= vote ^ (^shreg) ^ PARITY_ODD;
          state <= STOP;
        end
`endif
        STOP: if (vote_tick) begin
          if (!vote) state <= WAIT_IDLE;
          else if (stop_idx == 1'(STOP_BITS - 1)) state <= IDLE;
          else stop_idx <= 1'b1;
        end
        WAIT_IDLE: if (rx) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

  // FIFO storage, written only when the push is accepted
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[FAW-1:0]] <= {TERM_EN != 0 && char == TERM_BYTE, char};

  // FIFO pointers with wrap bit; occupancy is their difference
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule
